counter_nch: RTL

Parametrised N-channel programmable counter/timer, the next-generation replacement for the fixed 3-channel counter peripheral on the MIO bus. It runs entirely in the CPU clock domain: each channel derives its count rate from an internal prescaler, not from external divided clocks. Per channel it offers one-shot, periodic, square-wave and PWM modes, plus sticky interrupt flags and count readback. The CPU programs it through the same counter_we / counter_ch / counter_val strobe scheme the bus decoder already produces.

---
 rtl/counter_nch.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/counter_nch.sv
// counter_nch: N-channel programmable counter/timer with per-channel prescaler,
// one-shot / periodic / square / PWM modes, sticky interrupts and count readback.
module counter_nch #(
    parameter int NCH   = 4,
    parameter int CH_W  = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             counter_we,
    input  logic [CH_W-1:0]  counter_ch,
    input  logic [1:0]       counter_reg,
    input  logic [WIDTH-1:0] counter_val,
    output logic [WIDTH-1:0] rd_data,
    output logic [NCH-1:0]   cnt_out,
    output logic [NCH-1:0]   irq,
    output logic             irq_any
);
    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_SQUARE   = 2'd2,
        MODE_PWM      = 2'd3
    } mode_e;

    localparam logic [1:0] REG_RELOAD  = 2'd0;
    localparam logic [1:0] REG_CTRL    = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_IRQ_CLR = 2'd3;

    logic [7:0]                wr_presc;
    logic [NCH-1:0]            clr_mask;
    logic [NCH-1:0][WIDTH-1:0] count_all;
    logic [WIDTH-1:0]          rd_data_q;
    logic [WIDTH-1:0]          rd_data_d;

    // Shift-and-cast keeps the prescale field well defined even for narrow WIDTH.
    assign wr_presc = 8'(counter_val >> 8);
    assign clr_mask = (counter_we && counter_reg == REG_IRQ_CLR) ? NCH'(counter_val) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [WIDTH-1:0] count_q, count_d;
            logic [WIDTH-1:0] reload_q, reload_d;
            logic [WIDTH-1:0] compare_q, compare_d;
            mode_e            mode_q, mode_d;
            logic             en_q, en_d;
            logic             irq_en_q, irq_en_d;
            logic [7:0]       presc_max_q, presc_max_d;
            logic [7:0]       presc_q, presc_d;
            logic             cnt_out_q, cnt_out_d;
            logic             irq_q, irq_d;
            logic             sel, wr_reload, wr_ctrl, wr_cmp;
            logic             tick, te, te_act;

            always_comb begin
                sel       = counter_we && (counter_ch == CH_W'(gi));
                wr_reload = sel && (counter_reg == REG_RELOAD);
                wr_ctrl   = sel && (counter_reg == REG_CTRL);
                wr_cmp    = sel && (counter_reg == REG_COMPARE);
                tick      = en_q && (presc_q >= presc_max_q);
                te        = tick && (count_q == '0);
                // A colliding RELOAD/CTRL write overrides every TE effect except the irq set.
                te_act    = te && !wr_reload && !wr_ctrl;

                count_d     = count_q;
                reload_d    = reload_q;
                compare_d   = compare_q;
                mode_d      = mode_q;
                en_d        = en_q;
                irq_en_d    = irq_en_q;
                presc_max_d = presc_max_q;
                presc_d     = presc_q;
                cnt_out_d   = cnt_out_q;

                if (en_q) begin
                    presc_d = tick ? 8'd0 : presc_q + 8'd1;
                    if (tick && !te)
                        count_d = count_q - WIDTH'(1);
                    if (mode_q == MODE_PERIODIC)
                        cnt_out_d = 1'b0;
                    if (mode_q == MODE_PWM)
                        cnt_out_d = (count_q < compare_q);
                    if (te_act) begin
                        case (mode_q)
                            MODE_ONESHOT: begin
                                cnt_out_d = 1'b1;
                                en_d      = 1'b0;
                            end
                            MODE_PERIODIC: begin
                                count_d   = reload_q;
                                cnt_out_d = 1'b1;
                            end
                            MODE_SQUARE: begin
                                count_d   = reload_q;
                                cnt_out_d = ~cnt_out_q;
                            end
                            default: count_d = reload_q;
                        endcase
                    end
                end

                if (wr_reload) begin
                    reload_d = counter_val;
                    if (en_q) begin
                        count_d = counter_val;
                        presc_d = 8'd0;
                    end
                end

                if (wr_cmp)
                    compare_d = counter_val;

                if (wr_ctrl) begin
                    mode_d      = mode_e'(counter_val[1:0]);
                    en_d        = counter_val[2];
                    irq_en_d    = counter_val[3];
                    presc_max_d = wr_presc;
                    if (!counter_val[2]) begin
                        count_d   = count_q;
                        presc_d   = presc_q;
                        cnt_out_d = cnt_out_q;
                    end else if (!en_q) begin
                        count_d   = reload_q;
                        presc_d   = 8'd0;
                        cnt_out_d = 1'b0;
                    end
                end

                irq_d = irq_q;
                if (clr_mask[gi])
                    irq_d = 1'b0;
                if (te && irq_en_q)
                    irq_d = 1'b1;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_q     <= '0;
                    reload_q    <= '0;
                    compare_q   <= '0;
                    mode_q      <= MODE_ONESHOT;
                    en_q        <= 1'b0;
                    irq_en_q    <= 1'b0;
                    presc_max_q <= 8'd0;
                    presc_q     <= 8'd0;
                    cnt_out_q   <= 1'b0;
                    irq_q       <= 1'b0;
                end else begin
                    count_q     <= count_d;
                    reload_q    <= reload_d;
                    compare_q   <= compare_d;
                    mode_q      <= mode_d;
                    en_q        <= en_d;
                    irq_en_q    <= irq_en_d;
                    presc_max_q <= presc_max_d;
                    presc_q     <= presc_d;
                    cnt_out_q   <= cnt_out_d;
                    irq_q       <= irq_d;
                end
            end

            assign count_all[gi] = count_q;
            assign cnt_out[gi]   = cnt_out_q;
            assign irq[gi]       = irq_q;
        end
    endgenerate

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (counter_ch == CH_W'(i))
                rd_data_d = count_all[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data_q <= '0;
        else
            rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
    assign irq_any = |irq;

endmodule
